// File: rtl/adc_clkgen_sequencer.sv
`timescale 1ns/1ps
// Counter-based ADC clock sequencer: synchronises start_conv/comp_trig and runs
// NBITS comparator/SAR clock cycles with programmable delays, timeout and status.
module adc_clkgen_sequencer #(
  parameter int unsigned NBITS   = 12,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_in,
  input  logic             start_conv,
  input  logic             comp_trig,
  input  logic [CNT_W-1:0] cfg_dly_dig,
  input  logic [CNT_W-1:0] cfg_dly_comp,
  output logic             clk_comp,
  output logic             clk_dig,
  output logic             busy,
  output logic             conv_done,
  output logic             timeout
);

  localparam int unsigned BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMP,
    S_DIG,
    S_RECOV,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   dly_q, dly_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic               wait_lo_q, wait_lo_d;
  logic               clk_comp_q, clk_comp_d;
  logic               clk_dig_q, clk_dig_d;
  logic               busy_q, busy_d;
  logic               conv_done_q, conv_done_d;
  logic               timeout_q, timeout_d;

  logic               start_meta_q, start_s_q, start_dly_q;
  logic               comp_meta_q, comp_s_q;
  logic               start_edge;
  logic               tmo_expired;
  logic               finish_bit;
  logic [CNT_W-1:0]   dly_dig_eff, dly_comp_eff;

  // Two-flop synchronisers plus one extra flop for start edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_meta_q <= 1'b0;
      start_s_q    <= 1'b0;
      start_dly_q  <= 1'b0;
      comp_meta_q  <= 1'b0;
      comp_s_q     <= 1'b0;
    end else begin
      start_meta_q <= start_conv;
      start_s_q    <= start_meta_q;
      start_dly_q  <= start_s_q;
      comp_meta_q  <= comp_trig;
      comp_s_q     <= comp_meta_q;
    end
  end

  assign start_edge   = start_s_q & ~start_dly_q;
  assign tmo_expired  = (tmo_q == CNT_W'(TMO_CYC - 1));
  assign dly_dig_eff  = (cfg_dly_dig  == '0) ? CNT_W'(1) : cfg_dly_dig;
  assign dly_comp_eff = (cfg_dly_comp == '0) ? CNT_W'(1) : cfg_dly_comp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      dly_q       <= '0;
      tmo_q       <= '0;
      wait_lo_q   <= 1'b0;
      clk_comp_q  <= 1'b0;
      clk_dig_q   <= 1'b0;
      busy_q      <= 1'b0;
      conv_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      dly_q       <= dly_d;
      tmo_q       <= tmo_d;
      wait_lo_q   <= wait_lo_d;
      clk_comp_q  <= clk_comp_d;
      clk_dig_q   <= clk_dig_d;
      busy_q      <= busy_d;
      conv_done_q <= conv_done_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next state; every output is decoded from the next state and registered
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    dly_d      = dly_q;
    tmo_d      = tmo_q;
    wait_lo_d  = wait_lo_q;
    clk_dig_d  = 1'b0;
    timeout_d  = 1'b0;
    finish_bit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge || ena_in) begin
          state_d   = S_COMP;
          bit_cnt_d = BIT_W'(NBITS - 1);
          tmo_d     = '0;
        end
      end
      S_COMP: begin
        if (comp_s_q) begin
          state_d   = S_DIG;
          dly_d     = dly_dig_eff - CNT_W'(1);
          clk_dig_d = (dly_dig_eff == CNT_W'(1));
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_DIG: begin
        if (clk_dig_q) begin
          state_d   = S_RECOV;
          tmo_d     = '0;
          wait_lo_d = 1'b1;
        end else begin
          dly_d     = dly_q - CNT_W'(1);
          clk_dig_d = (dly_q == CNT_W'(1));
        end
      end
      S_RECOV: begin
        // First wait for the comparator to release, then count recovery cycles
        if (wait_lo_q) begin
          if (!comp_s_q) begin
            wait_lo_d = 1'b0;
            if (dly_comp_eff == CNT_W'(1)) begin
              finish_bit = 1'b1;
            end else begin
              dly_d = dly_comp_eff - CNT_W'(1);
            end
          end else if (tmo_expired) begin
            timeout_d = 1'b1;
            wait_lo_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            tmo_d = tmo_q + CNT_W'(1);
          end
        end else if (dly_q == CNT_W'(1)) begin
          finish_bit = 1'b1;
        end else begin
          dly_d = dly_q - CNT_W'(1);
        end
        if (finish_bit) begin
          if (bit_cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            tmo_d     = '0;
            state_d   = S_COMP;
          end
        end
      end
      S_DONE: begin
        if (ena_in) begin
          state_d   = S_COMP;
          bit_cnt_d = BIT_W'(NBITS - 1);
          tmo_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    clk_comp_d  = (state_d == S_COMP) || (state_d == S_DIG);
    busy_d      = (state_d != S_IDLE);
    conv_done_d = (state_d == S_DONE);
  end

  assign clk_comp  = clk_comp_q;
  assign clk_dig   = clk_dig_q;
  assign busy      = busy_q;
  assign conv_done = conv_done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_adc_clkgen_sequencer.sv
`timescale 1ns/1ps
// Bench for adc_clkgen_sequencer: timestamp-based reference model, reactive
// comparator model, directed scenarios and a randomized soak.
module tb_adc_clkgen_sequencer;

  localparam int unsigned NB  = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned TMO = 10;

  logic          clk = 1'b0;
  logic          rst_n, ena_in, start_conv, comp_trig;
  logic [CW-1:0] cfg_dig, cfg_comp;
  logic          clk_comp, clk_dig, busy, conv_done, timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  time t_pos = 0;

  adc_clkgen_sequencer #(.NBITS(NB), .CNT_W(CW), .TMO_CYC(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena_in       (ena_in),
    .start_conv   (start_conv),
    .comp_trig    (comp_trig),
    .cfg_dly_dig  (cfg_dig),
    .cfg_dly_comp (cfg_comp),
    .clk_comp     (clk_comp),
    .clk_dig      (clk_dig),
    .busy         (busy),
    .conv_done    (conv_done),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    t_pos = $time;
  end

  // Comparator: rises lat_hi clocks after clk_comp rises, falls lat_lo after it falls
  int cmp_mode = 0;
  bit lat_rand = 1'b0;
  int hi_at = -1;
  int lo_at = -1;

  initial begin
    logic prev_comp;
    prev_comp = 1'b0;
    forever begin
      @(negedge clk);
      if (clk_comp && !prev_comp) hi_at = cyc + (lat_rand ? int'($urandom_range(1, 6)) : 5);
      if (!clk_comp && prev_comp) begin
        lo_at = cyc + (lat_rand ? int'($urandom_range(1, 4)) : 2);
        hi_at = -1;
      end
      prev_comp = clk_comp;
    end
  end

  initial begin
    comp_trig = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (cmp_mode)
        0: begin
          if (hi_at >= 0 && cyc >= hi_at) begin comp_trig = 1'b1; hi_at = -1; end
          if (lo_at >= 0 && cyc >= lo_at) begin comp_trig = 1'b0; lo_at = -1; end
        end
        1: comp_trig = 1'b0;
        default: if ($urandom_range(0, 3) == 0) comp_trig = ~comp_trig;
      endcase
    end
  end

  // Reference model: phases with absolute deadlines (edge numbers), not counters
  localparam int M_IDLE = 0, M_HI = 1, M_DIG = 2, M_LO = 3, M_REC = 4, M_DONE = 5;
  int   m_mode, mn, t_ent, t_dig, t_next, bits_left;
  logic m_meta, m_s, m_sd, c_meta, c_s;
  logic e_comp, e_dig, e_busy, e_done, e_tmo;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = M_IDLE; mn = 0; t_ent = 0; t_dig = 0; t_next = 0; bits_left = 0;
      m_meta = 0; m_s = 0; m_sd = 0; c_meta = 0; c_s = 0;
      e_comp = 0; e_dig = 0; e_busy = 0; e_done = 0; e_tmo = 0;
    end else begin
      int d_eff, r_eff;
      logic se, cs;
      mn++;
      se    = m_s && !m_sd;
      cs    = c_s;
      d_eff = (cfg_dig  == '0) ? 1 : int'(cfg_dig);
      r_eff = (cfg_comp == '0) ? 1 : int'(cfg_comp);
      e_dig = 1'b0;
      e_tmo = 1'b0;
      case (m_mode)
        M_IDLE: if (se || ena_in) begin m_mode = M_HI; t_ent = mn; bits_left = NB; end
        M_HI: begin
          if (cs) begin m_mode = M_DIG; t_dig = mn - 1 + d_eff; end
          else if (mn - t_ent == TMO) begin e_tmo = 1'b1; m_mode = M_IDLE; end
        end
        M_DIG: if (mn == t_dig + 1) begin m_mode = M_LO; t_ent = mn; end
        M_LO: begin
          if (!cs) begin m_mode = M_REC; t_next = mn - 1 + r_eff; end
          else if (mn - t_ent == TMO) begin e_tmo = 1'b1; m_mode = M_IDLE; end
        end
        M_DONE: begin
          if (ena_in) begin m_mode = M_HI; t_ent = mn; bits_left = NB; end
          else m_mode = M_IDLE;
        end
        default: ;
      endcase
      if (m_mode == M_DIG && mn == t_dig) e_dig = 1'b1;
      if (m_mode == M_REC && mn == t_next) begin
        bits_left--;
        if (bits_left == 0) m_mode = M_DONE;
        else begin m_mode = M_HI; t_ent = mn; end
      end
      e_comp = (m_mode == M_HI) || (m_mode == M_DIG);
      e_busy = (m_mode != M_IDLE);
      e_done = (m_mode == M_DONE);
      m_sd = m_s; m_s = m_meta; m_meta = start_conv;
      c_s = c_meta; c_meta = comp_trig;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("clk_comp",  int'(clk_comp),  int'(e_comp));
    chk("clk_dig",   int'(clk_dig),   int'(e_dig));
    chk("busy",      int'(busy),      int'(e_busy));
    chk("conv_done", int'(conv_done), int'(e_done));
    chk("timeout",   int'(timeout),   int'(e_tmo));
  end

  // Generated clocks may only move on a rising clk edge, or asynchronously in reset
  initial forever begin
    @(clk_comp or clk_dig);
    total++;
    if (rst_n && $time != t_pos) begin
      bad++;
      $display("FAIL glitch: clk_comp=%0b clk_dig=%0b changed at %0t, last edge %0t",
               clk_comp, clk_dig, $time, t_pos);
    end
  end

  int n_dig = 0, n_comp = 0, n_done = 0, n_tmo = 0, n_bf = 0;
  int dig_lat = -1, comp_rise_cyc = -1, tmo_cyc = -1, trig_rise_cyc = -1;

  initial begin
    logic p_dig, p_comp, p_done, p_tmo, p_busy, p_trig;
    p_dig = 0; p_comp = 0; p_done = 0; p_tmo = 0; p_busy = 0; p_trig = 0;
    forever begin
      @(negedge clk);
      if (comp_trig && !p_trig) trig_rise_cyc = cyc;
      if (clk_dig && !p_dig) begin n_dig++; dig_lat = cyc - trig_rise_cyc; end
      if (clk_comp && !p_comp) begin n_comp++; comp_rise_cyc = cyc; end
      if (conv_done && !p_done) n_done++;
      if (timeout && !p_tmo) begin n_tmo++; tmo_cyc = cyc; end
      if (!busy && p_busy) n_bf++;
      p_dig = clk_dig; p_comp = clk_comp; p_done = conv_done;
      p_tmo = timeout; p_busy = busy; p_trig = comp_trig;
    end
  end

  task automatic wait_busy(input string nm, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < budget);
    chk({nm, "_busy"}, int'(busy), 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < budget);
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_conv = 1'b1;
    repeat (2) @(negedge clk);
    start_conv = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b_dig, b_done, b_comp, b_tmo, b_bf, s_cyc, n;
    rst_n = 1'b0; ena_in = 1'b0; start_conv = 1'b0;
    cfg_dig = CW'(3); cfg_comp = CW'(2);
    repeat (3) @(negedge clk);
    chk("rst_clk_comp",  int'(clk_comp),  0);
    chk("rst_clk_dig",   int'(clk_dig),   0);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_conv_done", int'(conv_done), 0);
    chk("rst_timeout",   int'(timeout),   0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single conversion
    b_dig = n_dig; b_done = n_done; b_comp = n_comp;
    s_cyc = cyc;
    start_conv = 1'b1;
    n = 0;
    while (!clk_comp && n < 10) begin @(negedge clk); n++; end
    start_conv = 1'b0;
    chk("t1_start_lat", cyc - s_cyc, 3);
    wait_idle("t1", 300);
    chk("t1_dig_pulses", n_dig - b_dig, 4);
    chk("t1_comp_pulses", n_comp - b_comp, 4);
    chk("t1_done", n_done - b_done, 1);
    chk("t1_dig_lat", dig_lat, 5);

    // Continuous mode
    b_dig = n_dig; b_done = n_done; b_bf = n_bf;
    ena_in = 1'b1;
    n = 0;
    while (n_done - b_done < 3 && n < 400) begin @(negedge clk); n++; end
    chk("t2_three_done", n_done - b_done, 3);
    repeat (10) @(negedge clk);
    ena_in = 1'b0;
    wait_idle("t2", 200);
    chk("t2_done", n_done - b_done, 4);
    chk("t2_dig_pulses", n_dig - b_dig, 16);
    chk("t2_busy_falls", n_bf - b_bf, 1);

    // Comparator stuck low
    cmp_mode = 1;
    b_dig = n_dig; b_done = n_done; b_tmo = n_tmo;
    pulse_start();
    wait_busy("t3", 10);
    wait_idle("t3", 50);
    chk("t3_tmo_lat", tmo_cyc - comp_rise_cyc, 10);
    chk("t3_tmo_cnt", n_tmo - b_tmo, 1);
    chk("t3_done", n_done - b_done, 0);
    chk("t3_dig_pulses", n_dig - b_dig, 0);
    cmp_mode = 0;
    repeat (3) @(negedge clk);

    // Start edge while busy is dropped
    b_dig = n_dig; b_done = n_done;
    pulse_start();
    wait_busy("t4", 10);
    repeat (25) @(negedge clk);
    pulse_start();
    wait_idle("t4", 300);
    repeat (10) @(negedge clk);
    chk("t4_not_queued", int'(busy), 0);
    chk("t4_dig_pulses", n_dig - b_dig, 4);
    chk("t4_done", n_done - b_done, 1);

    // Reset during DIG
    pulse_start();
    n = 0;
    while (!comp_trig && n < 40) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("t5_pre_clk_comp", int'(clk_comp), 1);
    b_done = n_done;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_clk_comp",  int'(clk_comp),  0);
    chk("t5_rst_clk_dig",   int'(clk_dig),   0);
    chk("t5_rst_busy",      int'(busy),      0);
    chk("t5_rst_conv_done", int'(conv_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (comp_trig && n < 20) begin @(negedge clk); n++; end
    chk("t5_no_done", n_done - b_done, 0);
    b_dig = n_dig; b_done = n_done;
    pulse_start();
    wait_busy("t5", 10);
    wait_idle("t5", 300);
    chk("t5_dig_pulses", n_dig - b_dig, 4);
    chk("t5_done", n_done - b_done, 1);

    // Zero delay configuration behaves as one
    cfg_dig = '0; cfg_comp = '0;
    b_dig = n_dig; b_done = n_done;
    pulse_start();
    wait_busy("t6", 10);
    wait_idle("t6", 300);
    chk("t6_dig_pulses", n_dig - b_dig, 4);
    chk("t6_done", n_done - b_done, 1);
    chk("t6_dig_lat", dig_lat, 3);

    // Randomized soak against the model
    lat_rand = 1'b1;
    for (int seg = 0; seg < 60; seg++) begin
      n = int'($urandom_range(0, 9));
      cmp_mode = (n < 7) ? 0 : ((n < 8) ? 1 : 2);
      cfg_dig  = CW'($urandom_range(0, 4));
      cfg_comp = CW'($urandom_range(0, 4));
      ena_in   = ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(20, 60)) begin
        @(negedge clk);
        start_conv = ($urandom_range(0, 7) == 0);
      end
    end
    ena_in = 1'b0; start_conv = 1'b0; cmp_mode = 1;
    wait_idle("drain", 200);
    cmp_mode = 0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
